dmem_req_unit: RTL and testbench
================================

Name: dmem_req_unit

Overview:
- Data-memory request stage directly downstream of the store formatting unit in the MEM stage.
- Takes one load or store per instruction: address, formatted write data and byte strobes.
- Runs one transaction on the data bus using a valid/ready request phase and an rvalid response phase.
- Stalls the pipeline until the transaction completes, then returns raw read data and an error flag to the load/writeback path.
- Provides a bus timeout and flush handling.

Parameters:
- TIMEOUT_CYCLES, 255: cycles spent in ADDR plus DATA before the transaction is aborted with an error; legal range 1..65535.
- CNT_W, 16: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  MEM stage holds a memory instruction.
- req_we_i  in  1  1 = store, 0 = load.
- req_addr_i  in  32  byte address.
- req_wstrb_i  in  4  byte strobes from the store unit.
- req_wdata_i  in  32  lane-aligned write data.
- flush_i  in  1  kill the current MEM instruction.
- stall_o  out  1  hold the pipeline.
- rsp_valid_o  out  1  one-cycle completion pulse.
- rsp_rdata_o  out  32  raw read word; 0 for stores and errors.
- rsp_err_o  out  1  bus error or timeout, qualified by rsp_valid_o.
- mem_valid_o  out  1  bus request valid.
- mem_we_o  out  1  bus write enable.
- mem_addr_o  out  32  word-aligned address ({req_addr_i[31:2],2'b00}).
- mem_wstrb_o  out  4  bus strobes; 0 for reads.
- mem_wdata_o  out  32  bus write data.
- mem_ready_i  in  1  bus accepts the request.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  32  read data.
- mem_err_i  in  1  error, sampled with rvalid (reads) or ready (writes).

Behaviour:
- Reset:
  - state = IDLE, counter = 0, drop flag = 0.
  - All outputs 0, including mem_* registers and rsp_rdata_o.
  - Reset in any state aborts immediately; mem_valid_o is 0 the next cycle.
- States: IDLE, ADDR, DATA, RESP.
- IDLE:
  - Accept when req_valid_i=1 and flush_i=0.
  - Capture we, word-aligned addr, wdata; capture wstrb for stores, 0 for loads.
  - Store with req_wstrb_i==0: go directly to RESP, err=0, no bus transaction.
  - Otherwise go to ADDR.
- ADDR:
  - mem_valid_o=1, all mem_* outputs held stable.
  - On mem_ready_i=1:
    - Store: go to RESP, err = mem_err_i.
    - Load: go to DATA.
  - mem_valid_o is never withdrawn before a handshake except on reset or timeout.
- DATA:
  - mem_valid_o=0.
  - On mem_rvalid_i=1: capture mem_rdata_i and mem_err_i, go to RESP.
  - mem_rvalid_i in any other state is ignored.
- RESP (exactly one cycle):
  - rsp_valid_o = ~drop.
  - rsp_rdata_o = captured data for a successful load, else 0.
  - rsp_err_o = captured error.
  - Next state IDLE. No new request is accepted in RESP.
- stall_o:
  - Combinational: (state==ADDR) | (state==DATA) | (state==IDLE & req_valid_i & ~flush_i).
  - 0 in RESP.
- Latency:
  - Best-case load (ready in cycle 1, rvalid in cycle 2): request at T0, rsp_valid_o at T3.
  - Best-case store: rsp_valid_o at T2.
- Timeout:
  - Counter clears on entry to ADDR and increments each cycle in ADDR or DATA.
  - When counter == TIMEOUT_CYCLES-1 and the completing handshake is absent: go to RESP with err=1, rdata=0; mem_valid_o drops.
  - A handshake in the same cycle as the timeout wins.
- Flush:
  - In IDLE: blocks acceptance.
  - In ADDR/DATA: sets drop. The bus transaction still completes, and RESP is entered with rsp_valid_o=0, rsp_err_o=0.
  - drop clears on leaving RESP.
- Back-to-back requests: a new instruction is accepted in the IDLE cycle following RESP, giving at least one IDLE cycle between transactions.

Test Plan:
- Load, addr 0x1003: ready at T1, rvalid at T2 with rdata 0xDEADBEEF -> mem_addr_o=0x1000, mem_wstrb_o=0, rsp_valid_o=1 at T3, rsp_rdata_o=0xDEADBEEF, stall_o=1 for T0..T2 and 0 at T3.
- Store, wstrb 4'b1100, wdata 0xAB000000, ready held low 5 cycles -> mem_valid_o/addr/wdata stable for all 5 cycles, rsp_valid_o exactly 1 cycle after the ready handshake, rsp_rdata_o=0.
- Store with wstrb 0 -> mem_valid_o never asserts, rsp_valid_o=1 at T1, rsp_err_o=0.
- Load with TIMEOUT_CYCLES=4, bus silent -> mem_valid_o high 4 cycles, then rsp_valid_o=1, rsp_err_o=1, rsp_rdata_o=0, followed by IDLE.
- flush_i pulsed during DATA, rvalid arriving later -> no rsp_valid_o, stall_o drops at RESP, next req_valid_i accepted in the following IDLE.
- rst_i asserted in ADDR -> next cycle all outputs 0, state IDLE, a subsequent load completes normally.

Source files
------------

// File: rtl/dmem_req_unit.sv
// Data-memory request stage: runs one valid/ready + rvalid bus transaction per MEM
// instruction, stalling the pipeline until the response, with timeout and flush drop.
module dmem_req_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [3:0]  req_wstrb_i,
  input  logic [31:0] req_wdata_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        mem_valid_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_wstrb_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ready_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             drop_q, err_q;
  logic [31:0]      rdata_q;
  logic             accept, tmo;
  logic             unused_addr_lsb;

  assign accept          = (state_q == IDLE) & req_valid_i & ~flush_i;
  // >= so a load whose ready lands on the last cycle still times out in DATA
  assign tmo             = (cnt_q >= CNT_LAST);
  assign unused_addr_lsb = ^req_addr_i[1:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (req_we_i && req_wstrb_i == 4'h0) ? RESP : ADDR;
      ADDR: begin
        if (mem_ready_i)  state_d = mem_we_o ? RESP : DATA;
        else if (tmo)     state_d = RESP;
      end
      DATA: if (mem_rvalid_i || tmo) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      drop_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wstrb_o <= '0;
      mem_wdata_o <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (accept) begin
          mem_we_o    <= req_we_i;
          mem_addr_o  <= {req_addr_i[31:2], 2'b00};
          mem_wstrb_o <= req_we_i ? req_wstrb_i : 4'h0;
          mem_wdata_o <= req_wdata_i;
          err_q       <= 1'b0;
          rdata_q     <= '0;
          cnt_q       <= '0;
          drop_q      <= 1'b0;
        end
        ADDR, DATA: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (flush_i) drop_q <= 1'b1;
          // a completing handshake takes priority over the timeout
          if (state_q == ADDR && mem_ready_i) begin
            if (mem_we_o) err_q <= mem_err_i;
          end else if (state_q == DATA && mem_rvalid_i) begin
            rdata_q <= mem_rdata_i;
            err_q   <= mem_err_i;
          end else if (tmo) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        end
        RESP: drop_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign mem_valid_o = (state_q == ADDR);
  assign stall_o     = (state_q == ADDR) | (state_q == DATA) | accept;
  assign rsp_valid_o = (state_q == RESP) & ~drop_q;
  assign rsp_err_o   = rsp_valid_o & err_q;
  assign rsp_rdata_o = (rsp_valid_o & ~mem_we_o & ~err_q) ? rdata_q : 32'h0;
endmodule

// File: tb/tb_dmem_req_unit.sv
// Bench for dmem_req_unit: directed scenarios plus a randomized bus-latency sweep,
// with expected responses queued at request time and popped on rsp_valid.
module tb_dmem_req_unit;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 0, req_we = 0, flush = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, mem_rdata = 0;
  logic [3:0]  req_wstrb = 0;
  logic        mem_ready = 0, mem_rvalid = 0, mem_err = 0;

  logic        stall, rsp_valid, rsp_err, mem_valid, mem_we;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        t_stall, t_rsp_valid, t_rsp_err, t_mem_valid, t_mem_we;
  logic [31:0] t_rsp_rdata, t_mem_addr, t_mem_wdata;
  logic [3:0]  t_mem_wstrb;

  typedef struct {logic [31:0] rdata; logic err;} exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  dmem_req_unit #(.TIMEOUT_CYCLES(255), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wstrb_i(req_wstrb), .req_wdata_i(req_wdata),
    .flush_i(flush), .stall_o(stall), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .mem_valid_o(mem_valid), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wstrb_o(mem_wstrb), .mem_wdata_o(mem_wdata), .mem_ready_i(mem_ready),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .mem_err_i(mem_err));

  dmem_req_unit #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut_to (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wstrb_i(req_wstrb), .req_wdata_i(req_wdata),
    .flush_i(flush), .stall_o(t_stall), .rsp_valid_o(t_rsp_valid), .rsp_rdata_o(t_rsp_rdata),
    .rsp_err_o(t_rsp_err), .mem_valid_o(t_mem_valid), .mem_we_o(t_mem_we), .mem_addr_o(t_mem_addr),
    .mem_wstrb_o(t_mem_wstrb), .mem_wdata_o(t_mem_wdata), .mem_ready_i(mem_ready),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .mem_err_i(mem_err));

  task automatic drive_req(input logic we, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wstrb = s; req_wdata = d;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1; req_valid = 0; mem_ready = 0; mem_rvalid = 0; mem_err = 0; flush = 0;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_chk++; if ({stall, rsp_valid, rsp_err, mem_valid, mem_we, rsp_rdata, mem_addr, mem_wstrb, mem_wdata} !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", {stall, rsp_valid, rsp_err, mem_valid, mem_we, rsp_rdata, mem_addr, mem_wstrb, mem_wdata}); end
    n_chk++; if ({t_stall, t_rsp_valid, t_rsp_err, t_mem_valid, t_rsp_rdata, t_mem_addr} !== '0) begin n_fail++; $display("FAIL reset_outputs_to: got %h want 0", {t_stall, t_rsp_valid, t_rsp_err, t_mem_valid, t_rsp_rdata, t_mem_addr}); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_load();
    exp_t e;
    sb.delete();
    @(negedge clk); drive_req(1'b0, 32'h1003, 4'hF, 32'h5555_5555);
    sb.push_back('{rdata: 32'hDEADBEEF, err: 1'b0}); #1;
    n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL load_stall_t0: got %b want 1", stall); end
    @(negedge clk); req_valid = 0; mem_ready = 1; #1;
    n_chk++; if ({mem_valid, mem_addr, mem_wstrb, stall} !== {1'b1, 32'h1000, 4'h0, 1'b1}) begin n_fail++; $display("FAIL load_addr_t1: got v=%b a=%h s=%h st=%b want 1/00001000/0/1", mem_valid, mem_addr, mem_wstrb, stall); end
    @(negedge clk); mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'hDEADBEEF; #1;
    n_chk++; if ({stall, mem_valid} !== 2'b10) begin n_fail++; $display("FAIL load_data_t2: got st=%b v=%b want 1/0", stall, mem_valid); end
    @(negedge clk); mem_rvalid = 0; #1;
    n_chk++; if ({rsp_valid, stall} !== 2'b10) begin n_fail++; $display("FAIL load_rsp_t3: got rv=%b st=%b want 1/0", rsp_valid, stall); end
    if (rsp_valid) begin
      e = sb.pop_front();
      n_chk++; if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin n_fail++; $display("FAIL load_rsp_data: got %h/%b want %h/%b", rsp_rdata, rsp_err, e.rdata, e.err); end
    end
    @(negedge clk); #1;
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL load_rsp_pulse: got %b want 0", rsp_valid); end
  endtask

  task automatic test_store_wait();
    exp_t e;
    sb.delete();
    @(negedge clk); drive_req(1'b1, 32'h2002, 4'b1100, 32'hAB00_0000);
    sb.push_back('{rdata: 32'h0, err: 1'b0}); #1;
    n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL store_stall_t0: got %b want 1", stall); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); req_valid = 0; mem_ready = 0; #1;
      n_chk++; if ({mem_valid, mem_we, mem_wstrb, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'hC, 32'h2000, 32'hAB00_0000}) begin n_fail++; $display("FAIL store_hold_%0d: got v=%b we=%b s=%h a=%h d=%h", c, mem_valid, mem_we, mem_wstrb, mem_addr, mem_wdata); end
    end
    @(negedge clk); mem_ready = 1; #1;
    n_chk++; if ({mem_valid, rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL store_handshake: got v=%b rv=%b want 1/0", mem_valid, rsp_valid); end
    @(negedge clk); mem_ready = 0; #1;
    n_chk++; if ({rsp_valid, mem_valid} !== 2'b10) begin n_fail++; $display("FAIL store_rsp: got rv=%b v=%b want 1/0", rsp_valid, mem_valid); end
    if (rsp_valid) begin
      e = sb.pop_front();
      n_chk++; if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin n_fail++; $display("FAIL store_rsp_data: got %h/%b want %h/%b", rsp_rdata, rsp_err, e.rdata, e.err); end
    end
    @(negedge clk); #1;
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL store_rsp_pulse: got %b want 0", rsp_valid); end
  endtask

  task automatic test_store_nostrb();
    @(negedge clk); drive_req(1'b1, 32'h2100, 4'h0, 32'h1234_5678); #1;
    n_chk++; if ({stall, mem_valid} !== 2'b10) begin n_fail++; $display("FAIL nostrb_t0: got st=%b v=%b want 1/0", stall, mem_valid); end
    @(negedge clk); req_valid = 0; #1;
    n_chk++; if ({rsp_valid, rsp_err, mem_valid, stall, rsp_rdata} !== {4'b1000, 32'h0}) begin n_fail++; $display("FAIL nostrb_t1: got rv=%b e=%b v=%b st=%b d=%h want 1/0/0/0/0", rsp_valid, rsp_err, mem_valid, stall, rsp_rdata); end
    @(negedge clk); #1;
    n_chk++; if ({rsp_valid, mem_valid} !== 2'b00) begin n_fail++; $display("FAIL nostrb_t2: got rv=%b v=%b want 0/0", rsp_valid, mem_valid); end
  endtask

  task automatic test_timeout();
    pulse_reset();
    @(negedge clk); drive_req(1'b0, 32'h40, 4'hF, 32'h0);
    @(negedge clk); req_valid = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_chk++; if ({t_mem_valid, t_rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL tmo_addr_%0d: got v=%b rv=%b want 1/0", c, t_mem_valid, t_rsp_valid); end
      @(negedge clk);
    end
    #1;
    n_chk++; if ({t_mem_valid, t_rsp_valid, t_rsp_err, t_rsp_rdata} !== {3'b011, 32'h0}) begin n_fail++; $display("FAIL tmo_rsp: got v=%b rv=%b e=%b d=%h want 0/1/1/0", t_mem_valid, t_rsp_valid, t_rsp_err, t_rsp_rdata); end
    @(negedge clk); #1;
    n_chk++; if ({t_rsp_valid, t_stall, t_mem_valid} !== 3'b000) begin n_fail++; $display("FAIL tmo_idle: got rv=%b st=%b v=%b want 0/0/0", t_rsp_valid, t_stall, t_mem_valid); end
    // handshake on the final cycle wins over the timeout
    pulse_reset();
    @(negedge clk); drive_req(1'b1, 32'h44, 4'hF, 32'h77);
    repeat (3) begin @(negedge clk); req_valid = 0; end
    @(negedge clk); mem_ready = 1; mem_err = 0;
    @(negedge clk); mem_ready = 0; #1;
    n_chk++; if ({t_rsp_valid, t_rsp_err} !== 2'b10) begin n_fail++; $display("FAIL tmo_handshake_wins: got rv=%b e=%b want 1/0", t_rsp_valid, t_rsp_err); end
    pulse_reset();
  endtask

  task automatic test_flush();
    exp_t e;
    sb.delete();
    @(negedge clk); drive_req(1'b0, 32'h3000, 4'hF, 32'h0);
    @(negedge clk); req_valid = 0; mem_ready = 1;
    @(negedge clk); mem_ready = 0; flush = 1; #1;
    n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL flush_stall_data: got %b want 1", stall); end
    @(negedge clk); flush = 0;
    @(negedge clk); mem_rvalid = 1; mem_rdata = 32'h1234_5678;
    @(negedge clk); mem_rvalid = 0; drive_req(1'b0, 32'h3004, 4'hF, 32'h0); #1;
    n_chk++; if ({rsp_valid, rsp_err, stall} !== 3'b000) begin n_fail++; $display("FAIL flush_dropped: got rv=%b e=%b st=%b want 0/0/0", rsp_valid, rsp_err, stall); end
    sb.push_back('{rdata: 32'hCAFE_F00D, err: 1'b0});
    @(negedge clk); #1;
    n_chk++; if ({stall, mem_valid} !== 2'b10) begin n_fail++; $display("FAIL flush_next_accept: got st=%b v=%b want 1/0", stall, mem_valid); end
    @(negedge clk); req_valid = 0; mem_ready = 1; #1;
    n_chk++; if ({mem_valid, mem_addr} !== {1'b1, 32'h3004}) begin n_fail++; $display("FAIL flush_next_addr: got v=%b a=%h want 1/00003004", mem_valid, mem_addr); end
    @(negedge clk); mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk); mem_rvalid = 0; #1;
    n_chk++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL flush_next_rsp: got %b want 1", rsp_valid); end
    if (rsp_valid) begin
      e = sb.pop_front();
      n_chk++; if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin n_fail++; $display("FAIL flush_next_data: got %h/%b want %h/%b", rsp_rdata, rsp_err, e.rdata, e.err); end
    end
  endtask

  task automatic test_reset_in_addr();
    exp_t e;
    sb.delete();
    @(negedge clk); drive_req(1'b1, 32'h5004, 4'hF, 32'h1122_3344);
    @(negedge clk); req_valid = 0; #1;
    n_chk++; if ({mem_valid, mem_we} !== 2'b11) begin n_fail++; $display("FAIL rst_pre_addr: got v=%b we=%b want 1/1", mem_valid, mem_we); end
    rst = 1;
    @(negedge clk); rst = 0; #1;
    n_chk++; if ({stall, rsp_valid, rsp_err, mem_valid, mem_we, rsp_rdata, mem_addr, mem_wstrb, mem_wdata} !== '0) begin n_fail++; $display("FAIL rst_in_addr: got %h want 0", {stall, rsp_valid, rsp_err, mem_valid, mem_we, rsp_rdata, mem_addr, mem_wstrb, mem_wdata}); end
    @(negedge clk); drive_req(1'b0, 32'h6000, 4'hF, 32'h0);
    sb.push_back('{rdata: 32'h0BAD_F00D, err: 1'b0});
    @(negedge clk); req_valid = 0; mem_ready = 1;
    @(negedge clk); mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h0BAD_F00D;
    @(negedge clk); mem_rvalid = 0; #1;
    n_chk++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rst_after_rsp: got %b want 1", rsp_valid); end
    if (rsp_valid) begin
      e = sb.pop_front();
      n_chk++; if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin n_fail++; $display("FAIL rst_after_data: got %h/%b want %h/%b", rsp_rdata, rsp_err, e.rdata, e.err); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic we, er, addr_done, got;
    logic [3:0] s;
    logic [31:0] a, d, rd;
    int rdly, vdly;
    sb.delete();
    for (int i = 0; i < 24; i++) begin
      we = 1'($urandom_range(0, 1)); er = ($urandom_range(0, 3) == 0);
      s = (i % 6 == 3) ? 4'h0 : 4'($urandom_range(0, 15));
      if (i % 6 == 3) we = 1'b1;
      a = $urandom; d = $urandom; rd = $urandom;
      rdly = $urandom_range(0, 3); vdly = $urandom_range(0, 3);
      @(negedge clk); drive_req(we, a, s, d);
      if (we) sb.push_back('{rdata: 32'h0, err: (s == 4'h0) ? 1'b0 : er});
      else    sb.push_back('{rdata: er ? 32'h0 : rd, err: er});
      @(negedge clk); req_valid = 0; addr_done = 0; got = 0;
      for (int c = 0; c < 40 && !got; c++) begin
        #1;
        mem_ready = 0; mem_rvalid = 0; mem_err = 0;
        if (rsp_valid) begin
          got = 1;
          n_chk++;
          if (sb.size() == 0) begin n_fail++; $display("FAIL b2b_sb_empty txn %0d", i); end
          else begin
            e = sb.pop_front();
            if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin n_fail++; $display("FAIL b2b_rsp txn %0d: got %h/%b want %h/%b", i, rsp_rdata, rsp_err, e.rdata, e.err); end
          end
        end else if (mem_valid) begin
          if (rdly == 0) begin
            mem_ready = 1; mem_err = we & er; addr_done = 1;
            n_chk++; if ({mem_we, mem_addr, mem_wstrb} !== {we, a[31:2], 2'b00, (we ? s : 4'h0)}) begin n_fail++; $display("FAIL b2b_bus txn %0d: got we=%b a=%h s=%h", i, mem_we, mem_addr, mem_wstrb); end
          end else rdly--;
        end else if (addr_done) begin
          if (vdly == 0) begin mem_rvalid = 1; mem_rdata = rd; mem_err = er; end
          else vdly--;
        end
        if (!got) @(negedge clk);
      end
      mem_ready = 0; mem_rvalid = 0; mem_err = 0;
      n_chk++; if (!got) begin n_fail++; $display("FAIL b2b_no_rsp txn %0d: got none want rsp_valid within 40 cycles", i); end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store_wait();
    test_store_nostrb();
    test_flush();
    test_reset_in_addr();
    test_back_to_back();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
